// File: rtl/axi_pkg.sv
// Shared AXI encodings and the W-channel FSM state type for the write generator.
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] LOCK_NORMAL = 2'b00;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } w_state_e;

    // Fibonacci LFSR step, polynomial x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; push is dropped when full, pop ignored when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_srst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                     (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
    assign o_cnt   = r_wr_ptr - r_rd_ptr;
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/axi_mst_wr_gen.sv
// AXI3 write-traffic generator: turns commands into INCR bursts, sends PRBS write data in AW
// order and tracks outstanding writes and error responses.
module axi_mst_wr_gen
    import axi_pkg::*;
#(
    parameter int unsigned         AXI_ADDR_W  = 32,
    parameter int unsigned         AXI_ID_W    = 4,
    parameter int unsigned         AXI_DATA_W  = 32,
    parameter int unsigned         OSTD_NUM    = 4,
    parameter logic [AXI_ID_W-1:0] MST_ID_MASK = AXI_ID_W'(4'b0100),
    parameter logic [31:0]         LFSR_SEED   = 32'hACE1_0001
) (
    input  logic                      aclk,
    input  logic                      srst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ADDR_W-1:0]     cmd_addr,
    input  logic [3:0]                cmd_len,
    input  logic [AXI_ID_W-1:0]       cmd_id,
    output logic                      awvalid,
    output logic [AXI_ADDR_W-1:0]     awaddr,
    output logic [3:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic [AXI_ID_W-1:0]       awid,
    output logic [1:0]                awlock,
    input  logic                      awready,
    output logic                      wvalid,
    output logic                      wlast,
    output logic [AXI_ID_W-1:0]       wid,
    output logic [AXI_DATA_W-1:0]     wdata,
    output logic [AXI_DATA_W/8-1:0]   wstrb,
    input  logic                      wready,
    input  logic                      bvalid,
    output logic                      bready,
    input  logic [AXI_ID_W-1:0]       bid,
    input  logic [1:0]                bresp,
    output logic [$clog2(OSTD_NUM):0] ostd_cnt,
    output logic [7:0]                err_cnt,
    output logic                      idle
);

    localparam int unsigned CNT_W  = $clog2(OSTD_NUM) + 1;
    localparam int unsigned FIFO_W = 4 + AXI_ID_W;
    localparam int unsigned STRB_W = AXI_DATA_W / 8;

    logic                  r_aw_vld;
    logic [AXI_ADDR_W-1:0] r_awaddr;
    logic [3:0]            r_awlen;
    logic [AXI_ID_W-1:0]   r_awid;
    w_state_e              r_state;
    w_state_e              w_state_d;
    logic [3:0]            r_beat;
    logic [31:0]           r_lfsr;
    logic [CNT_W-1:0]      r_ostd_cnt;
    logic [7:0]            r_err_cnt;

    logic                  w_cmd_hs;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_fifo_pop;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_cnt;
    logic [FIFO_W-1:0]     w_fifo_head;
    logic [3:0]            w_head_len;
    logic                  w_unused;

    assign w_cmd_hs = cmd_valid && cmd_ready;
    assign w_aw_hs  = r_aw_vld && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_b_hs   = bvalid && bready;
    assign w_unused = ^{bid, bresp[0]};

    // AW holding register
    assign cmd_ready = !r_aw_vld && (r_ostd_cnt < CNT_W'(OSTD_NUM));

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_aw_vld <= 1'b0;
        end else if (w_cmd_hs) begin
            r_aw_vld <= 1'b1;
        end else if (w_aw_hs) begin
            r_aw_vld <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_cmd_hs) begin
            r_awaddr <= cmd_addr;
            r_awlen  <= cmd_len;
            r_awid   <= cmd_id | MST_ID_MASK;
        end
    end

    assign awvalid = r_aw_vld;
    assign awaddr  = r_awaddr;
    assign awlen   = r_awlen;
    assign awid    = r_awid;
    assign awsize  = 3'($clog2(STRB_W));
    assign awburst = BURST_INCR;
    assign awlock  = LOCK_NORMAL;

    // Entries enter only on AW handshake, so W can never lead its AW.
    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (OSTD_NUM)
    ) u_wcmd_fifo (
        .i_clk   (aclk),
        .i_srst  (srst),
        .i_push  (w_aw_hs),
        .i_data  ({r_awlen, r_awid}),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_cnt   (w_fifo_cnt)
    );

    assign w_head_len = w_fifo_head[FIFO_W-1 -: 4];
    assign wid        = w_fifo_head[AXI_ID_W-1:0];

    // W-channel FSM
    always_ff @(posedge aclk) begin
        if (srst) r_state <= StIdle;
        else      r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (!w_fifo_empty) w_state_d = StBurst;
            StBurst: if (w_fifo_pop && (w_fifo_cnt == CNT_W'(1)) && !w_aw_hs) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    assign wvalid     = (r_state == StBurst);
    assign wlast      = wvalid && (r_beat == w_head_len);
    assign w_fifo_pop = w_w_hs && wlast;
    assign wstrb      = {STRB_W{wvalid}};

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_beat <= '0;
            r_lfsr <= LFSR_SEED;
        end else if (w_w_hs) begin
            r_beat <= wlast ? 4'd0 : r_beat + 4'd1;
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    for (genvar i = 0; i < AXI_DATA_W; i++) begin : g_wdata
        assign wdata[i] = r_lfsr[i % 32];
    end

    // Outstanding and error accounting
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_ostd_cnt <= '0;
        end else if (w_aw_hs && !w_b_hs && (r_ostd_cnt < CNT_W'(OSTD_NUM))) begin
            r_ostd_cnt <= r_ostd_cnt + 1'b1;
        end else if (!w_aw_hs && w_b_hs) begin
            r_ostd_cnt <= r_ostd_cnt - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_err_cnt <= '0;
        end else if (w_b_hs && bresp[1] && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bready   = (r_ostd_cnt != '0);
    assign ostd_cnt = r_ostd_cnt;
    assign err_cnt  = r_err_cnt;
    assign idle     = !r_aw_vld && w_fifo_empty && (r_state == StIdle) && (r_ostd_cnt == '0);

endmodule

// File: tb/tb_axi_mst_wr_gen.sv
// Directed bench for axi_mst_wr_gen: a per-cycle vector table for a single burst, then
// hand-written sequences for back-pressure, outstanding limit, errors and reset.
module tb_axi_mst_wr_gen;
    import axi_pkg::*;

    localparam logic [31:0] SEED    = 32'hACE1_0001;
    localparam logic [3:0]  ID_MASK = 4'b0100;

    logic        clk = 1'b0;
    logic        srst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len, cmd_id;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awlen, awid;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic        wvalid, wlast, wready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic [2:0]  ostd_cnt;
    logic [7:0]  err_cnt;
    logic        idle;

    int n_chk = 0;
    int n_err = 0;

    int          aw_cnt = 0;
    logic [31:0] wd_q[$];
    logic        wl_q[$];

    always #5 clk = ~clk;

    axi_mst_wr_gen u_dut (
        .aclk(clk), .srst(srst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_id(cmd_id),
        .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awid(awid), .awlock(awlock), .awready(awready),
        .wvalid(wvalid), .wlast(wlast), .wid(wid), .wdata(wdata), .wstrb(wstrb),
        .wready(wready),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .ostd_cnt(ostd_cnt), .err_cnt(err_cnt), .idle(idle)
    );

    // Handshake monitor; values read here are the pre-edge ones the DUT samples.
    always @(posedge clk) begin
        if (!srst) begin
            if (awvalid && awready) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready) begin
                wd_q.push_back(wdata);
                wl_q.push_back(wlast);
            end
        end
    end

    typedef struct {
        logic cmd_valid;
        logic bvalid;
        logic e_cmd_ready;
        logic e_awvalid;
        logic e_wvalid;
        logic e_wlast;
        logic e_bready;
        logic e_idle;
        int   e_ostd;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    task automatic do_reset();
        srst = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = RESP_OKAY;
        repeat (2) @(negedge clk);
        srst = 1'b0;
    endtask

    task automatic issue_cmd(input logic [31:0] a, input logic [3:0] l, input logic [3:0] id,
                             output bit ok);
        ok = 1'b0;
        cmd_addr = a; cmd_len = l; cmd_id = id; cmd_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ostd(input int exp, input int budget, input string nm);
        int c = 0;
        while (int'(ostd_cnt) != exp && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(nm, 64'(ostd_cnt), 64'(exp));
    endtask

    vec_t        tbl[9];
    logic [31:0] exp_lfsr[8];
    logic        wv[16], wl[16];
    logic [3:0]  c_len[2], c_id[2];
    bit          ok;
    int          base, c, first, n_hs, ci;

    initial begin
        // valid bv | rdy awv wv wl brdy idle ostd
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};

        exp_lfsr[0] = SEED;
        for (int k = 1; k < 8; k++) exp_lfsr[k] = model_next(exp_lfsr[k-1]);

        // Single burst len=3 id=1, cycle by cycle
        do_reset();
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        awready = 1'b1; wready = 1'b1;
        cmd_addr = 32'h0000_1000; cmd_len = 4'd3; cmd_id = 4'd1;
        for (int i = 0; i < 9; i++) begin
            cmd_valid = tbl[i].cmd_valid;
            bvalid    = tbl[i].bvalid;
            bresp     = RESP_OKAY;
            chk($sformatf("t%0d_cmd_ready", i), 64'(cmd_ready), 64'(tbl[i].e_cmd_ready));
            chk($sformatf("t%0d_awvalid", i), 64'(awvalid), 64'(tbl[i].e_awvalid));
            chk($sformatf("t%0d_wvalid", i), 64'(wvalid), 64'(tbl[i].e_wvalid));
            chk($sformatf("t%0d_wlast", i), 64'(wlast), 64'(tbl[i].e_wlast));
            chk($sformatf("t%0d_bready", i), 64'(bready), 64'(tbl[i].e_bready));
            chk($sformatf("t%0d_idle", i), 64'(idle), 64'(tbl[i].e_idle));
            chk($sformatf("t%0d_ostd", i), 64'(ostd_cnt), 64'(tbl[i].e_ostd));
            chk($sformatf("t%0d_wstrb", i), 64'(wstrb), tbl[i].e_wvalid ? 64'hF : 64'h0);
            if (tbl[i].e_awvalid) begin
                chk($sformatf("t%0d_awid", i), 64'(awid), 64'(ID_MASK | 4'd1));
                chk($sformatf("t%0d_awaddr", i), 64'(awaddr), 64'h1000);
                chk($sformatf("t%0d_awlen", i), 64'(awlen), 64'(3));
                chk($sformatf("t%0d_awsize", i), 64'(awsize), 64'(2));
                chk($sformatf("t%0d_awburst", i), 64'(awburst), 64'(1));
                chk($sformatf("t%0d_awlock", i), 64'(awlock), 64'(0));
            end
            if (tbl[i].e_wvalid) chk($sformatf("t%0d_wid", i), 64'(wid), 64'(ID_MASK | 4'd1));
            @(negedge clk);
        end

        // Outstanding limit: five commands, no B until the limit is reached
        do_reset();
        awready = 1'b1; wready = 1'b1;
        base = aw_cnt;
        for (int k = 0; k < 4; k++) begin
            issue_cmd(32'h2000 + 32'(k * 16), 4'd0, 4'(k), ok);
            chk($sformatf("a_accept%0d", k), 64'(ok), 64'(1));
        end
        @(negedge clk);
        cmd_addr = 32'h2040; cmd_len = 4'd0; cmd_id = 4'd4; cmd_valid = 1'b1;
        repeat (8) @(negedge clk);
        chk("a_cmd_ready_blocked", 64'(cmd_ready), 64'(0));
        chk("a_ostd4", 64'(ostd_cnt), 64'(4));
        chk("a_aw_count4", 64'(aw_cnt - base), 64'(4));
        bvalid = 1'b1; bresp = RESP_OKAY;
        @(negedge clk);
        bvalid = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        c = 0;
        while (aw_cnt - base < 5 && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("a_aw_count5", 64'(aw_cnt - base), 64'(5));
        chk("a_ostd_back4", 64'(ostd_cnt), 64'(4));
        bvalid = 1'b1;
        wait_ostd(0, 20, "a_drain");
        bvalid = 1'b0;
        c = 0;
        while (!idle && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("a_idle", 64'(idle), 64'(1));

        // Back-pressure: wready toggles every cycle on a len=7 burst
        do_reset();
        awready = 1'b1; wready = 1'b0;
        base = wd_q.size();
        issue_cmd(32'h3000, 4'd7, 4'd2, ok);
        chk("b_accept", 64'(ok), 64'(1));
        n_hs = 0;
        for (int k = 0; k < 80 && n_hs < 8; k++) begin
            if (wvalid) begin
                chk($sformatf("b_wdata_h%0d", n_hs), 64'(wdata), 64'(exp_lfsr[n_hs]));
                chk($sformatf("b_wlast_h%0d", n_hs), 64'(wlast), 64'(n_hs == 7));
            end
            wready = ~wready;
            if (wvalid && wready) n_hs++;
            @(negedge clk);
        end
        wready = 1'b1;
        chk("b_beats", 64'(wd_q.size() - base), 64'(8));
        for (int k = 0; k < 8 && base + k < wd_q.size(); k++) begin
            chk($sformatf("b_beat%0d_data", k), 64'(wd_q[base + k]), 64'(exp_lfsr[k]));
            chk($sformatf("b_beat%0d_last", k), 64'(wl_q[base + k]), 64'(k == 7));
        end

        // Back-to-back bursts len=0 then len=2 without a bubble
        do_reset();
        awready = 1'b1; wready = 1'b1;
        c_len[0] = 4'd0; c_id[0] = 4'd3;
        c_len[1] = 4'd2; c_id[1] = 4'd8;
        ci = 0;
        for (int k = 0; k < 16; k++) begin
            wv[k] = wvalid;
            wl[k] = wlast;
            if (ci < 2) begin
                cmd_valid = 1'b1; cmd_addr = 32'h4000; cmd_len = c_len[ci]; cmd_id = c_id[ci];
                if (cmd_ready) ci++;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        first = -1;
        for (int k = 0; k < 16; k++) if (first < 0 && wv[k]) first = k;
        chk("c_wvalid_seen", 64'(first >= 0), 64'(1));
        if (first >= 0 && first <= 11) begin
            for (int k = 0; k < 4; k++) chk($sformatf("c_wvalid%0d", k), 64'(wv[first + k]), 64'(1));
            chk("c_wvalid_end", 64'(wv[first + 4]), 64'(0));
            chk("c_wlast0", 64'(wl[first]), 64'(1));
            chk("c_wlast1", 64'(wl[first + 1]), 64'(0));
            chk("c_wlast2", 64'(wl[first + 2]), 64'(0));
            chk("c_wlast3", 64'(wl[first + 3]), 64'(1));
        end
        bvalid = 1'b1;
        wait_ostd(0, 20, "c_drain");
        bvalid = 1'b0;

        // Error responses and simultaneous AW/B handshakes
        do_reset();
        awready = 1'b1; wready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue_cmd(32'h5000, 4'd0, 4'(k), ok);
            chk($sformatf("d_accept%0d", k), 64'(ok), 64'(1));
        end
        wait_ostd(3, 20, "d_ostd3");
        bvalid = 1'b1; bresp = RESP_SLVERR;
        @(negedge clk);
        bresp = RESP_SLVERR;
        @(negedge clk);
        bresp = RESP_DECERR;
        @(negedge clk);
        bvalid = 1'b0; bresp = RESP_OKAY;
        chk("d_err_cnt3", 64'(err_cnt), 64'(3));
        chk("d_ostd0", 64'(ostd_cnt), 64'(0));
        issue_cmd(32'h5100, 4'd0, 4'd5, ok);
        wait_ostd(1, 20, "d_ostd1");
        awready = 1'b0;
        issue_cmd(32'h5200, 4'd0, 4'd6, ok);
        chk("d_aw_held", 64'(awvalid), 64'(1));
        base = aw_cnt;
        awready = 1'b1; bvalid = 1'b1; bresp = RESP_OKAY;
        @(negedge clk);
        bvalid = 1'b0;
        chk("d_ostd_same_cycle", 64'(ostd_cnt), 64'(1));
        chk("d_aw_done", 64'(aw_cnt - base), 64'(1));
        chk("d_err_unchanged", 64'(err_cnt), 64'(3));
        bvalid = 1'b1;
        wait_ostd(0, 20, "d_drain");
        @(negedge clk);
        chk("d_b_ignored_at_zero", 64'(ostd_cnt), 64'(0));
        chk("d_bready_low", 64'(bready), 64'(0));
        bvalid = 1'b0;

        // Reset in the middle of a len=5 burst
        do_reset();
        awready = 1'b1; wready = 1'b1;
        base = wd_q.size();
        issue_cmd(32'h6000, 4'd5, 4'd7, ok);
        c = 0;
        while (wd_q.size() - base < 1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("e_first_beat", 64'(wd_q.size() - base), 64'(1));
        chk("e_wvalid_beat2", 64'(wvalid), 64'(1));
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        chk("e_wvalid_cleared", 64'(wvalid), 64'(0));
        chk("e_ostd_cleared", 64'(ostd_cnt), 64'(0));
        chk("e_idle", 64'(idle), 64'(1));
        chk("e_awvalid", 64'(awvalid), 64'(0));
        chk("e_cmd_ready", 64'(cmd_ready), 64'(1));
        base = wd_q.size();
        c = aw_cnt;
        repeat (6) @(negedge clk);
        chk("e_no_more_beats", 64'(wd_q.size() - base), 64'(0));
        chk("e_no_aw_reissue", 64'(aw_cnt - c), 64'(0));
        issue_cmd(32'h7000, 4'd0, 4'd1, ok);
        chk("e_accept", 64'(ok), 64'(1));
        c = 0;
        while (wd_q.size() - base < 1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("e_restart_beat", 64'(wd_q.size() - base), 64'(1));
        if (wd_q.size() > base) chk("e_restart_seed", 64'(wd_q[base]), 64'(SEED));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
